read_emib: RTL and testbench

Reads a contiguous block of words out of the EMIB RAM and streams them to the management module (MM). It is the read-side counterpart of the EMIB write stage: the write stage fills the EMIB RAM at base + offset, and this block returns those words to the MM on request. It sits between the MM request logic and the EMIB RAM read port and drives that port's address and read-enable.

---
 rtl/read_emib_pkg.sv | 19 +
 rtl/read_emib_rd_pipe.sv | 28 ++
 rtl/read_emib.sv | 112 +++++++++++
 tb/tb_read_emib.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/read_emib_pkg.sv
// Shared EMIB read-side constants and the read FSM state encoding.
package read_emib_pkg;

   localparam int RAM_WIDTH = 8;
   localparam int ADDR_SZ   = 10;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      CHECK = 4'd1,
      READ  = 4'd2,
      DRAIN = 4'd3,
      DONE  = 4'd4,
      ERR   = 4'd5,
      WAIT1 = 4'd6,
      WAIT2 = 4'd7,
      WAIT3 = 4'd8
   } state_t;

endpackage

// File: rtl/read_emib_rd_pipe.sv
// Aligns the read strobe and word index with the EMIB RAM's one-cycle read latency.
module read_emib_rd_pipe
   import read_emib_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rd_en,
   input  logic [ADDR_SZ-1:0]   i_idx,
   input  logic [RAM_WIDTH-1:0] i_ram_data,
   output logic                 o_valid,
   output logic [ADDR_SZ-1:0]   o_idx,
   output logic [RAM_WIDTH-1:0] o_data
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_idx   <= '0;
      end else begin
         o_valid <= i_rd_en;
         o_idx   <= i_idx;
      end
   end

   // RAM output is already registered inside the RAM; gating keeps it 0 outside valid cycles and in reset.
   assign o_data = o_valid ? i_ram_data : '0;

endmodule

// File: rtl/read_emib.sv
// Streams a contiguous block of EMIB RAM words (base + offset, len words) back to the MM.
module read_emib
   import read_emib_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rd_en,
   input  logic                 i_error,
   input  logic [ADDR_SZ-1:0]   i_base_addr,
   input  logic [ADDR_SZ-1:0]   i_offset_addr,
   input  logic [ADDR_SZ-1:0]   i_rd_len,
   input  logic [RAM_WIDTH-1:0] i_emib_data,
   output logic [ADDR_SZ-1:0]   o_emib_addr,
   output logic                 o_emib_rd_en,
   output logic [RAM_WIDTH-1:0] o_mm_data,
   output logic                 o_mm_data_valid,
   output logic [ADDR_SZ-1:0]   o_mm_data_idx,
   output logic                 o_busy,
   output logic                 o_read_done,
   output logic                 o_read_error
);

   localparam logic [ADDR_SZ+1:0] ADDR_SPAN = {2'b01, {ADDR_SZ{1'b0}}};

   state_t               state;
   state_t               state_nxt;
   logic [ADDR_SZ-1:0]   base_r;
   logic [ADDR_SZ-1:0]   off_r;
   logic [ADDR_SZ-1:0]   len_r;
   logic [ADDR_SZ-1:0]   ptr;
   logic [ADDR_SZ-1:0]   ptr_nxt;
   logic [ADDR_SZ-1:0]   ptr_inc;
   logic [ADDR_SZ:0]     base_off;
   logic [ADDR_SZ+1:0]   range_end;
   logic                 reject;

   // Addresses never wrap, so the whole block must end at or below the top of the RAM.
   assign base_off  = {1'b0, base_r} + {1'b0, off_r};
   assign range_end = {1'b0, base_off} + {2'b00, len_r};
   assign reject    = i_error || (len_r == '0) || (range_end > ADDR_SPAN);
   assign ptr_inc   = ptr + ADDR_SZ'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = '0;
      case (state)
         IDLE:  if (i_rd_en) state_nxt = CHECK;
         CHECK: state_nxt = reject ? ERR : READ;
         READ: begin
            if (ptr_inc == len_r) begin
               state_nxt = DRAIN;
            end else begin
               ptr_nxt = ptr_inc;
            end
         end
         DRAIN: state_nxt = DONE;
         DONE:  state_nxt = WAIT1;
         ERR:   state_nxt = WAIT1;
         WAIT1: state_nxt = WAIT2;
         WAIT2: state_nxt = WAIT3;
         WAIT3: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         base_r       <= '0;
         off_r        <= '0;
         len_r        <= '0;
         ptr          <= '0;
         o_emib_addr  <= '0;
         o_emib_rd_en <= 1'b0;
         o_busy       <= 1'b0;
         o_read_done  <= 1'b0;
         o_read_error <= 1'b0;
      end else begin
         if (state == IDLE && i_rd_en) begin
            base_r <= i_base_addr;
            off_r  <= i_offset_addr;
            len_r  <= i_rd_len;
         end
         ptr          <= ptr_nxt;
         o_emib_rd_en <= (state_nxt == READ);
         o_emib_addr  <= (state_nxt == READ) ? (base_r + off_r + ptr_nxt) : '0;
         o_busy       <= (state_nxt != IDLE);
         o_read_done  <= (state_nxt == DONE);
         o_read_error <= (state_nxt == ERR);
      end
   end

   read_emib_rd_pipe u_rd_pipe (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_rd_en    (o_emib_rd_en),
      .i_idx      (ptr),
      .i_ram_data (i_emib_data),
      .o_valid    (o_mm_data_valid),
      .o_idx      (o_mm_data_idx),
      .o_data     (o_mm_data)
   );

endmodule

// File: tb/tb_read_emib.sv
// Directed bench for read_emib with a behavioural one-cycle-latency EMIB RAM.
module tb_read_emib;
   import read_emib_pkg::*;

   typedef struct packed {
      logic [ADDR_SZ-1:0] base;
      logic [ADDR_SZ-1:0] off;
      logic [ADDR_SZ-1:0] len;
      logic               err_in;
      logic               exp_reject;
   } vec_t;

   logic                 i_clk = 1'b0;
   logic                 i_rst_n = 1'b1;
   logic                 i_rd_en = 1'b0;
   logic                 i_error = 1'b0;
   logic [ADDR_SZ-1:0]   i_base_addr = '0;
   logic [ADDR_SZ-1:0]   i_offset_addr = '0;
   logic [ADDR_SZ-1:0]   i_rd_len = '0;
   logic [RAM_WIDTH-1:0] i_emib_data;
   logic [ADDR_SZ-1:0]   o_emib_addr;
   logic                 o_emib_rd_en;
   logic [RAM_WIDTH-1:0] o_mm_data;
   logic                 o_mm_data_valid;
   logic [ADDR_SZ-1:0]   o_mm_data_idx;
   logic                 o_busy;
   logic                 o_read_done;
   logic                 o_read_error;

   logic [RAM_WIDTH-1:0] mem [0:(1<<ADDR_SZ)-1];
   logic [RAM_WIDTH-1:0] ram_q = '0;
   int                   tests_run = 0;
   int                   tests_failed = 0;
   vec_t                 vecs [6];

   read_emib dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_rd_en         (i_rd_en),
      .i_error         (i_error),
      .i_base_addr     (i_base_addr),
      .i_offset_addr   (i_offset_addr),
      .i_rd_len        (i_rd_len),
      .i_emib_data     (i_emib_data),
      .o_emib_addr     (o_emib_addr),
      .o_emib_rd_en    (o_emib_rd_en),
      .o_mm_data       (o_mm_data),
      .o_mm_data_valid (o_mm_data_valid),
      .o_mm_data_idx   (o_mm_data_idx),
      .o_busy          (o_busy),
      .o_read_done     (o_read_done),
      .o_read_error    (o_read_error)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) begin
      if (o_emib_rd_en) ram_q <= mem[o_emib_addr];
   end
   assign i_emib_data = ram_q;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " addr"},  32'(o_emib_addr), 0);
      checkOutput({tag, " rd_en"}, 32'(o_emib_rd_en), 0);
      checkOutput({tag, " data"},  32'(o_mm_data), 0);
      checkOutput({tag, " valid"}, 32'(o_mm_data_valid), 0);
      checkOutput({tag, " idx"},   32'(o_mm_data_idx), 0);
      checkOutput({tag, " busy"},  32'(o_busy), 0);
      checkOutput({tag, " done"},  32'(o_read_done), 0);
      checkOutput({tag, " error"}, 32'(o_read_error), 0);
   endtask

   // k counts cycles after the start edge; expectations follow the documented T+k timeline.
   task automatic checkCycle(input int id, input int k, input int a, input int len, input logic rej);
      string tag;
      logic  exp_rd, exp_valid, exp_done, exp_err, exp_busy;
      tag       = $sformatf("v%0d k%0d", id, k);
      exp_rd    = !rej && k >= 2 && k <= 1 + len;
      exp_valid = !rej && k >= 3 && k <= 2 + len;
      exp_done  = !rej && k == 3 + len;
      exp_err   = rej && k == 2;
      exp_busy  = rej ? (k >= 1 && k <= 5) : (k >= 1 && k <= 6 + len);
      checkOutput({tag, " rd_en"}, 32'(o_emib_rd_en), 32'(exp_rd));
      if (exp_rd) checkOutput({tag, " addr"}, 32'(o_emib_addr), 32'(a + k - 2));
      checkOutput({tag, " valid"}, 32'(o_mm_data_valid), 32'(exp_valid));
      if (exp_valid) begin
         checkOutput({tag, " data"}, 32'(o_mm_data), 32'(mem[a + k - 3]));
         checkOutput({tag, " idx"},  32'(o_mm_data_idx), 32'(k - 3));
      end
      checkOutput({tag, " done"},  32'(o_read_done), 32'(exp_done));
      checkOutput({tag, " error"}, 32'(o_read_error), 32'(exp_err));
      checkOutput({tag, " busy"},  32'(o_busy), 32'(exp_busy));
   endtask

   // mode 0: plain request; 1: extra i_rd_en pulses in READ and WAIT2; 2: reset on the third valid word.
   task automatic applyStimulus(input vec_t v, input int id, input int mode);
      int a;
      int n;
      a = int'(v.base) + int'(v.off);
      n = v.exp_reject ? 8 : int'(v.len) + 9;
      i_base_addr   = v.base;
      i_offset_addr = v.off;
      i_rd_len      = v.len;
      i_error       = v.err_in;
      i_rd_en       = 1'b1;
      @(posedge i_clk);
      for (int k = 1; k <= n; k++) begin
         @(negedge i_clk);
         checkCycle(id, k, a, int'(v.len), v.exp_reject);
         if (k == 1) begin
            i_rd_en       = 1'b0;
            i_base_addr   = ~v.base;
            i_offset_addr = ~v.off;
            i_rd_len      = ~v.len;
         end
         if (k == 2) i_error = 1'b0;
         if (k == 3 && !v.err_in) i_error = 1'b1;
         if (k == 4) i_error = 1'b0;
         if (mode == 1 && k > 1) i_rd_en = (k == 4 || k == int'(v.len) + 5);
         if (mode == 2 && k == 5) begin
            i_rst_n = 1'b0;
            #1;
            checkAllZero($sformatf("v%0d reset", id));
            @(negedge i_clk);
            i_rst_n = 1'b1;
            for (int j = 0; j < 10; j++) begin
               @(negedge i_clk);
               checkOutput($sformatf("v%0d post-reset done j%0d", id, j), 32'(o_read_done), 0);
               checkOutput($sformatf("v%0d post-reset busy j%0d", id, j), 32'(o_busy), 0);
               checkOutput($sformatf("v%0d post-reset valid j%0d", id, j), 32'(o_mm_data_valid), 0);
            end
            break;
         end
      end
      i_rd_en = 1'b0;
      i_error = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_SZ); i++) mem[i] = RAM_WIDTH'(i ^ 8'h5A);
      mem[16'h20] = 8'h11;
      mem[16'h21] = 8'h22;
      mem[16'h22] = 8'h33;
      mem[16'h23] = 8'h44;

      #2 i_rst_n = 1'b0;
      #1;
      checkAllZero("reset");
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      //           base      offset    len       err   reject
      vecs[0] = '{10'h010, 10'h010, 10'd4,    1'b0, 1'b0};
      vecs[1] = '{10'h010, 10'h010, 10'd0,    1'b0, 1'b1};
      vecs[2] = '{10'h3F0, 10'h00F, 10'd2,    1'b0, 1'b1};
      vecs[3] = '{10'h010, 10'h010, 10'd4,    1'b1, 1'b1};
      vecs[4] = '{10'h3F0, 10'h00E, 10'd2,    1'b0, 1'b0};
      vecs[5] = '{10'h100, 10'h000, 10'd1,    1'b0, 1'b0};

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i], i, 0);
         @(negedge i_clk);
      end

      applyStimulus(vecs[0], 10, 1);
      @(negedge i_clk);
      applyStimulus(vecs[0], 11, 2);
      applyStimulus(vecs[0], 12, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
